// File: rtl/rollo_run_ctrl_if.sv
// Host/core-side bundle of the ROLLO run controller.
// Latency: n/a (wires only). Backpressure: none; cores answer with ready levels, host polls busy/done.
// master = controller view, slave = host/core-array view.
interface rollo_run_ctrl_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     go;
    logic [N_CH-1:0]          ch_start;
    logic [N_CH-1:0]          ch_ready;
    logic [N_CH*DATA_W-1:0]   ch_data;
    logic                     busy;
    logic                     done;
    logic [N_CH-1:0]          ch_fin;
    logic [N_CH-1:0]          ch_tout;
    logic [SEL_W-1:0]         rd_sel;
    logic [CNT_W-1:0]         rd_cycles;
    logic [DATA_W-1:0]        rd_data;

    modport master (
        input  go, ch_ready, ch_data, rd_sel,
        output ch_start, busy, done, ch_fin, ch_tout, rd_cycles, rd_data
    );

    modport slave (
        output go, ch_ready, ch_data, rd_sel,
        input  ch_start, busy, done, ch_fin, ch_tout, rd_cycles, rd_data
    );
endinterface

// File: rtl/rollo_run_ctrl.sv
// Launches N_CH ROLLO cores together, times each to its ready rising edge, latches its data word.
// Latency: done one cycle after the last channel completes; rd_* are a combinational read mux.
// Backpressure: none; go ignored outside IDLE. ROLLO_TIMEOUT_EN enables the per-channel TIMEOUT limit.
module rollo_run_ctrl #(
    parameter int N_CH      = 2,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int START_LEN = 1,
    parameter int TIMEOUT   = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    rollo_run_ctrl_if.master  bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int LW    = (START_LEN > 1) ? $clog2(START_LEN) : 1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef ROLLO_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      lcnt_q;
    logic [N_CH-1:0]    rdy_prev_q;
    logic [N_CH-1:0]    fin_q;
    logic [N_CH-1:0]    tout_q;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    tout_now;
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cyc_q [N_CH];
    logic [DATA_W-1:0]  dat_q [N_CH];
    logic               active;
    logic               accept_go;

    assign active    = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign accept_go = (state_q == S_IDLE) && bus.go;

    // A channel completes at most once per run; timeout only fires if it did not complete this cycle.
    always_comb begin
        rise     = '0;
        tout_now = '0;
        for (int i = 0; i < N_CH; i++) begin
            rise[i] = active && bus.ch_ready[i] && !rdy_prev_q[i] && !fin_q[i] && !tout_q[i];
            tout_now[i] = TOUT_EN && active && !fin_q[i] && !tout_q[i] && !rise[i]
                          && (cnt_q[i] == TO_CNT);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.go) state_d = S_LAUNCH;
            S_LAUNCH: if (lcnt_q == LW'(START_LEN - 1)) state_d = S_RUN;
            S_RUN:    if (&(fin_q | tout_q | rise | tout_now)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lcnt_q     <= '0;
            rdy_prev_q <= '1;
            fin_q      <= '0;
            tout_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                cyc_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rdy_prev_q <= bus.ch_ready;
            if (accept_go) begin
                lcnt_q <= '0;
                fin_q  <= '0;
                tout_q <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    cnt_q[i] <= '0;
                    cyc_q[i] <= '0;
                    dat_q[i] <= '0;
                end
            end else begin
                if (state_q == S_LAUNCH) lcnt_q <= lcnt_q + LW'(1);
                for (int i = 0; i < N_CH; i++) begin
                    if (active && !fin_q[i] && !tout_q[i] && !rise[i] && !tout_now[i]
                        && (cnt_q[i] != CNT_MAX))
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    if (rise[i]) begin
                        cyc_q[i] <= cnt_q[i];
                        dat_q[i] <= bus.ch_data[i*DATA_W +: DATA_W];
                        fin_q[i] <= 1'b1;
                    end
                    if (tout_now[i]) begin
                        cyc_q[i]  <= TO_CNT;
                        dat_q[i]  <= '0;
                        tout_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ch_start = {N_CH{state_q == S_LAUNCH}};
    assign bus.busy     = active;
    assign bus.done     = (state_q == S_DONE);
    assign bus.ch_fin   = fin_q;
    assign bus.ch_tout  = TOUT_EN ? tout_q : '0;

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        bus.rd_cycles = '0;
        bus.rd_data   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                bus.rd_cycles = cyc_q[i];
                bus.rd_data   = dat_q[i];
            end
        end
    end
endmodule

// File: tb/tb_rollo_run_ctrl.sv
// Directed bench for rollo_run_ctrl: a 1-channel and a 4-channel instance driven cycle by cycle.
// k is counted from LAUNCH cycle 0 (the cycle right after go is sampled).
module tb_rollo_run_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rollo_run_ctrl_if #(.N_CH(1), .DATA_W(32), .CNT_W(32)) if1();
    rollo_run_ctrl_if #(.N_CH(4), .DATA_W(32), .CNT_W(32)) if4();

    rollo_run_ctrl #(.N_CH(1), .DATA_W(32), .CNT_W(32), .START_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1));
    rollo_run_ctrl #(.N_CH(4), .DATA_W(32), .CNT_W(32), .START_LEN(2), .TIMEOUT(50)) u_dut4 (
        .clk(clk), .rst(rst), .bus(if4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] d4(input int ch, input int kk);
        return 32'((ch << 24) | kk);
    endfunction

    task automatic drive4(input int kk, input int rise[4]);
        for (int i = 0; i < 4; i++) begin
            if4.ch_data[i*32 +: 32] = d4(i, kk);
            if (rise[i] == kk) if4.ch_ready[i] = 1'b1;
        end
    endtask

    task automatic go4();
        if4.go = 1'b1;
        tick();
        if4.go = 1'b0;
    endtask

    task automatic read4(input string tag, input int ch, input logic [31:0] ecyc, input logic [31:0] edat);
        if4.rd_sel = 2'(ch);
        #1;
        chk({tag, "_cycles"}, if4.rd_cycles, ecyc);
        chk({tag, "_data"}, if4.rd_data, edat);
    endtask

    initial begin
        int ra[4];
        int rb[4];
        int rc[4];
        int rd[4];
        ra = '{-1, 5, 5, 5};
        rb = '{10, 25, 25, 7};
        rc = '{5, -1, 6, 7};
        rd = '{-1, -1, -1, 7};

        // Reset; channel 0 of the 4-ch instance holds ready high throughout.
        rst = 1'b1;
        if1.go = 1'b0; if1.ch_ready = 1'b0; if1.ch_data = '0; if1.rd_sel = 1'b0;
        if4.go = 1'b0; if4.ch_ready = 4'b0001; if4.ch_data = '0; if4.rd_sel = 2'd0;
        repeat (3) tick();
        chk("rst_start", if4.ch_start, 4'h0);
        chk("rst_busy", if4.busy, 1'b0);
        chk("rst_done", if4.done, 1'b0);
        chk("rst_fin", if4.ch_fin, 4'h0);
        chk("rst_tout", if4.ch_tout, 4'h0);
        chk("rst_cycles", if4.rd_cycles, 32'd0);
        chk("rst_data", if4.rd_data, 32'd0);
        chk("rst1_busy", if1.busy, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // Single channel: ready 100 cycles after start.
        if1.go = 1'b1;
        tick();
        if1.go = 1'b0;
        for (int kk = 0; kk <= 102; kk++) begin
            if (kk > 0) tick();
            if1.ch_data = (kk == 100) ? 32'hDEADBEEF : 32'(kk);
            if (kk == 100) if1.ch_ready = 1'b1;
            if (kk == 0) begin
                chk("one_busy_k0", if1.busy, 1'b1);
                chk("one_start_k0", if1.ch_start, 1'b1);
            end
            if (kk == 1) chk("one_start_k1", if1.ch_start, 1'b0);
            if (kk == 100) chk("one_done_k100", if1.done, 1'b0);
            if (kk == 101) begin
                chk("one_done_k101", if1.done, 1'b1);
                chk("one_busy_k101", if1.busy, 1'b0);
                chk("one_fin", if1.ch_fin, 1'b1);
            end
            if (kk == 102) chk("one_done_k102", if1.done, 1'b0);
        end
        chk("one_cycles", if1.rd_cycles, 32'd100);
        chk("one_data", if1.rd_data, 32'hDEADBEEF);
        if1.rd_sel = 1'b1;
        #1;
        chk("one_oob_cycles", if1.rd_cycles, 32'd0);
        chk("one_oob_data", if1.rd_data, 32'd0);
        if1.ch_ready = 1'b0;

        // Run A: ch0 stale-high ready falls at k=3, rises at k=40; others at k=5 together.
        go4();
        for (int kk = 0; kk <= 42; kk++) begin
            if (kk > 0) tick();
            drive4(kk, ra);
            if (kk == 3) if4.ch_ready[0] = 1'b0;
            if (kk == 40) if4.ch_ready[0] = 1'b1;
            if (kk == 0) begin
                chk("a_busy_k0", if4.busy, 1'b1);
                chk("a_start_k0", if4.ch_start, 4'hf);
            end
            if (kk == 1) chk("a_start_k1", if4.ch_start, 4'hf);
            if (kk == 2) chk("a_start_k2", if4.ch_start, 4'h0);
            if (kk == 6) chk("a_fin_k6", if4.ch_fin, 4'b1110);
            if (kk == 40) chk("a_done_k40", if4.done, 1'b0);
            if (kk == 41) begin
                chk("a_done_k41", if4.done, 1'b1);
                chk("a_busy_k41", if4.busy, 1'b0);
                chk("a_fin_k41", if4.ch_fin, 4'hf);
            end
            if (kk == 42) chk("a_done_k42", if4.done, 1'b0);
        end
        read4("a0", 0, 32'd40, d4(0, 40));
        read4("a1", 1, 32'd5, d4(1, 5));
        read4("a3", 3, 32'd5, d4(3, 5));
        if4.ch_ready = '0;
        if4.rd_sel = 2'd0;
        repeat (2) tick();

        // Run B: 10/25/25/7, with a go pulse mid-run that must be ignored.
        go4();
        for (int kk = 0; kk <= 27; kk++) begin
            if (kk > 0) tick();
            drive4(kk, rb);
            if (kk == 0) begin
                chk("b_fin_cleared", if4.ch_fin, 4'h0);
                chk("b_cycles_cleared", if4.rd_cycles, 32'd0);
            end
            if (kk == 12) if4.go = 1'b1;
            if (kk == 13) begin
                if4.go = 1'b0;
                chk("b_busy_after_go", if4.busy, 1'b1);
                chk("b_fin_k13", if4.ch_fin, 4'b1001);
            end
            if (kk == 25) chk("b_done_k25", if4.done, 1'b0);
            if (kk == 26) begin
                chk("b_done_k26", if4.done, 1'b1);
                chk("b_busy_k26", if4.busy, 1'b0);
            end
            if (kk == 27) chk("b_done_k27", if4.done, 1'b0);
        end
        read4("b0", 0, 32'd10, d4(0, 10));
        read4("b1", 1, 32'd25, d4(1, 25));
        read4("b2", 2, 32'd25, d4(2, 25));
        read4("b3", 3, 32'd7, d4(3, 7));
        if4.ch_ready = '0;
        repeat (2) tick();

        // Run C: channel 1 never becomes ready.
        go4();
        for (int kk = 0; kk <= 60; kk++) begin
            if (kk > 0) tick();
            drive4(kk, rc);
`ifdef ROLLO_TIMEOUT_EN
            if (kk == 50) begin
                chk("c_done_k50", if4.done, 1'b0);
                chk("c_tout_k50", if4.ch_tout, 4'h0);
            end
            if (kk == 51) begin
                chk("c_done_k51", if4.done, 1'b1);
                chk("c_tout_k51", if4.ch_tout, 4'b0010);
                chk("c_fin_k51", if4.ch_fin, 4'b1101);
            end
`else
            if (kk == 60) begin
                chk("c_busy_k60", if4.busy, 1'b1);
                chk("c_done_k60", if4.done, 1'b0);
                chk("c_fin_k60", if4.ch_fin, 4'b1101);
                chk("c_tout_k60", if4.ch_tout, 4'h0);
            end
`endif
        end
`ifdef ROLLO_TIMEOUT_EN
        read4("c1", 1, 32'd50, 32'd0);
`else
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c_busy_rst", if4.busy, 1'b0);
`endif
        if4.ch_ready = '0;
        repeat (2) tick();

        // Run D: reset asserted at k=20 discards the partial result of channel 3.
        go4();
        for (int kk = 0; kk <= 20; kk++) begin
            if (kk > 0) tick();
            drive4(kk, rd);
            if (kk == 8) chk("d_fin_k8", if4.ch_fin, 4'b1000);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("d_busy_rst", if4.busy, 1'b0);
        chk("d_start_rst", if4.ch_start, 4'h0);
        chk("d_fin_rst", if4.ch_fin, 4'h0);
        chk("d_done_rst", if4.done, 1'b0);
        read4("d3", 3, 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rollo_run_ctrl.md
# rollo_run_ctrl

Synthesizable run controller and cycle profiler for ROLLO encrypt/decrypt cores. It launches up to `N_CH` cores with a common start pulse and measures each core's latency in clock cycles. It captures each core's output word on completion and flags cores that never finish. It sits between the on-chip host or debug port and the core array, and provides in hardware the launch-and-measure function the simulation benches perform, across several cores at once.

## Interface
Parameters:
- `N_CH`, 2: number of core channels (1..16).
- `DATA_W`, 32: width of each core's data word.
- `CNT_W`, 32: cycle-counter width.
- `START_LEN`, 1: number of cycles `ch_start` is held high (≥1).
- `TIMEOUT`, 1048576: cycle limit per channel; used only when `ROLLO_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `go`, in, 1: launch request, sampled in IDLE only.
- `ch_start`, out, `N_CH`: start pulse to every core, all bits identical.
- `ch_ready`, in, `N_CH`: per-core ready/finished level.
- `ch_data`, in, `N_CH*DATA_W`: per-core data; channel i occupies bits [i*DATA_W +: DATA_W].
- `busy`, out, 1: high in LAUNCH and RUN.
- `done`, out, 1: one-cycle pulse when the run completes.
- `ch_fin`, out, `N_CH`: channel finished normally in the last run.
- `ch_tout`, out, `N_CH`: channel timed out in the last run.
- `rd_sel`, in, clog2(`N_CH`) (minimum 1): result read select.
- `rd_cycles`, out, `CNT_W`: latched cycle count of channel `rd_sel`.
- `rd_data`, out, `DATA_W`: latched data of channel `rd_sel`.

## Operation
- FSM states: IDLE → LAUNCH → RUN → DONE → IDLE.
- IDLE: when `go`=1, clear all counters, `ch_fin`, `ch_tout` and latched data, then enter LAUNCH.
- LAUNCH: hold `ch_start`=all ones for `START_LEN` cycles, then enter RUN. If `START_LEN`=1, LAUNCH lasts one cycle.
- Counter i is 0 in the first LAUNCH cycle. It increments every cycle while channel i is neither finished nor timed out, and saturates at 2^CNT_W−1.
- Completion of a channel is a rising edge of `ch_ready[i]`: sampled 1 this cycle and 0 in the previous cycle.
  - The previous-value register is reset to 1, so a ready level left high by an earlier run is ignored until it falls and rises again.
  - Completion is detected in both LAUNCH and RUN.
- On completion of channel i, in that same cycle: latch the counter value into `rd_cycles[i]`, latch `ch_data[i]` into `rd_data[i]`, and set `ch_fin[i]`. Later edges on that channel are ignored.
- RUN → DONE when every channel has `ch_fin` or `ch_tout` set.
- DONE lasts one cycle, asserts `done`, then returns to IDLE.
- Results hold until the next accepted `go`.
- `go` outside IDLE is ignored.
- `rd_cycles` and `rd_data` are combinational muxes of the latched registers selected by `rd_sel`. If `rd_sel` ≥ `N_CH`, both outputs are 0.

## Timing
- Reset values: `ch_start`=0, `busy`=0, `done`=0, `ch_fin`=0, `ch_tout`=0; all counters and latches 0; ready-history register all ones; state IDLE.
- Reset in any state returns to IDLE on the next edge, drops `ch_start` at once and discards the partial results.
- `go` sampled high at edge t:
  - `busy`=1 and `ch_start`=1 from t+1.
  - `ch_start` falls at t+1+`START_LEN`.
- If ready rises at edge t+1+k, counting LAUNCH cycle 0 as edge t+1, the channel reports k.
  - Example: `START_LEN`=1 and ready rising on the third RUN cycle gives k=3.
- `done` is high the cycle after the last channel completes. `busy` falls in the same cycle `done` rises.
- If all channels complete in the same cycle, each latches the same count and `done` follows one cycle later.

## Configuration
- `ROLLO_TIMEOUT_EN` defined:
  - A channel that is still running when its counter reaches `TIMEOUT` sets `ch_tout[i]` and stops counting.
  - `rd_cycles` then reads `TIMEOUT` and `rd_data` reads 0.
  - A later ready edge on that channel is ignored.
- `ROLLO_TIMEOUT_EN` undefined: no timeout logic, `ch_tout` is tied to 0, and the controller waits indefinitely.

## Test plan
- `N_CH`=1, `START_LEN`=1; core model asserts ready 100 cycles after start and drives data 0xDEADBEEF → `rd_cycles`=100, `rd_data`=0xDEADBEEF, `ch_fin`=1, one-cycle `done`.
- `N_CH`=4; cores finish at k=10, 25, 25, 7 → per-channel counts match, `done` one cycle after the k=25 edge.
- Ready held high from reset into launch, falls at k=3 and rises at k=40 → count 40.
- `go` pulsed during RUN → ignored, results unchanged. A second `go` in IDLE clears the previous results.
- `rst` at k=20 mid-run → next cycle `busy`=0, `ch_start`=0, all results 0.
- `ROLLO_TIMEOUT_EN` defined, `TIMEOUT`=50, channel 1 never ready → `ch_tout`=2'b10, `rd_cycles[1]`=50, `done` after cycle 50. With the macro undefined, `busy` stays high.
